// File: rtl/fir_pkg.sv
// fir_pkg
// Shared types, widths and helpers for the FIR MAC engine.
//   state_t      : engine sequencing states
//   DATA_W/COEF_W/ACC_W : sample, coefficient and accumulator widths
//   RAM_AW/RAM_DW: address and data width of the 256x36 block RAMs
//   signExtend   : widens a sample to a RAM word
//   fitResult    : reduces a shifted accumulator to an output sample
// Build option: FIR_SATURATE_EN makes fitResult clamp instead of wrap.
package fir_pkg;

    localparam int DATA_W = 24;
    localparam int COEF_W = 18;
    localparam int ACC_W  = 48;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int RAM_AW = 8;
    localparam int RAM_DW = 36;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

    // Replicates the sample sign bit into the unused upper RAM bits.
    function automatic logic [RAM_DW-1:0] signExtend(input logic [DATA_W-1:0] s);
        return {{(RAM_DW-DATA_W){s[DATA_W-1]}}, s};
    endfunction

    // The value fits in DATA_W bits only when every bit from the output
    // sign position upward agrees; otherwise clamp toward the sign of v.
    function automatic logic [DATA_W-1:0] fitResult(input logic [ACC_W-1:0] v);
`ifdef FIR_SATURATE_EN
        if ((&v[ACC_W-1:DATA_W-1]) || (~|v[ACC_W-1:DATA_W-1])) begin
            return v[DATA_W-1:0];
        end
        return v[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`else
        return v[DATA_W-1:0];
`endif
    endfunction

endpackage

// File: rtl/fir_mac.sv
// fir_mac
// Two-stage signed multiply-accumulate.
//   clk, rst  : clock and asynchronous active-high reset
//   i_clear   : zero the accumulator (has priority over i_acc_en)
//   i_acc_en  : add the registered product into the accumulator
//   i_a, i_b  : signed sample and coefficient
//   o_acc     : signed accumulator
// Stage 1 registers the full-width product every cycle; stage 2 adds it
// when the caller says the product corresponds to a real tap.
module fir_mac
    import fir_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_acc_en,
    input  logic signed [DATA_W-1:0] i_a,
    input  logic signed [COEF_W-1:0] i_b,
    output logic signed [ACC_W-1:0]  o_acc
);

    logic signed [PROD_W-1:0] r_prod;
    logic signed [ACC_W-1:0]  r_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod <= '0;
        end else begin
            r_prod <= i_a * i_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_acc_en) begin
            r_acc <= r_acc + {{(ACC_W-PROD_W){r_prod[PROD_W-1]}}, r_prod};
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/fir_mac_engine.sv
// fir_mac_engine
// Sequential FIR: stores each accepted sample in a circular history RAM,
// then walks NTAPS history/coefficient pairs through a MAC pipeline.
//   clk, rst          : clock, asynchronous active-high reset
//   i_sample_in/valid : input sample and its 1-cycle strobe
//   o_sample_ready    : engine idle, next sample will be accepted
//   o_hist_*          : history RAM port (write in WRITE, reads in READ)
//   i_hist_dout       : history RAM data, 1-cycle registered read
//   o_coef_addr       : coefficient RAM address
//   i_coef_dout       : coefficient RAM data, 1-cycle registered read
//   o_result/valid    : filtered sample and its 1-cycle strobe
//   o_overrun         : sticky, a sample arrived while busy
// Build option: FIR_SATURATE_EN clamps the result instead of wrapping.
module fir_mac_engine
    import fir_pkg::*;
#(
    parameter int NTAPS = 64,
    parameter int SHIFT = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_sample_in,
    input  logic              i_sample_valid,
    output logic              o_sample_ready,
    output logic              o_hist_we,
    output logic [RAM_AW-1:0] o_hist_addr,
    output logic [RAM_DW-1:0] o_hist_din,
    input  logic [RAM_DW-1:0] i_hist_dout,
    output logic [RAM_AW-1:0] o_coef_addr,
    input  logic [RAM_DW-1:0] i_coef_dout,
    output logic [DATA_W-1:0] o_result,
    output logic              o_result_valid,
    output logic              o_overrun
);

    localparam logic [RAM_AW-1:0] LAST_TAP   = RAM_AW'(NTAPS - 1);
    localparam logic [RAM_AW-1:0] LAST_DRAIN = RAM_AW'(2);

    state_t             r_state;
    state_t             w_next;
    logic [RAM_AW-1:0]  r_cnt;
    logic [RAM_AW-1:0]  r_wptr;
    logic [DATA_W-1:0]  r_sample;
    logic [1:0]         r_tapValid;
    logic [DATA_W-1:0]  r_result;
    logic               r_resultValid;
    logic               r_overrun;
    logic               w_accept;
    logic signed [ACC_W-1:0] w_acc;
    logic signed [ACC_W-1:0] w_shifted;
    logic               w_unused;

    assign w_accept  = (r_state == IDLE) && i_sample_valid;
    assign w_shifted = w_acc >>> SHIFT;
    assign w_unused  = ^{i_hist_dout[RAM_DW-1:DATA_W], i_coef_dout[RAM_DW-1:COEF_W]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state plus the RAM-side controls, all decoded from the state.
    always_comb begin
        w_next         = r_state;
        o_sample_ready = 1'b0;
        o_hist_we      = 1'b0;
        o_hist_addr    = '0;
        o_hist_din     = '0;
        o_coef_addr    = '0;
        case (r_state)
            IDLE: begin
                o_sample_ready = 1'b1;
                if (i_sample_valid) w_next = WRITE;
            end
            WRITE: begin
                o_hist_we   = 1'b1;
                o_hist_addr = r_wptr;
                o_hist_din  = signExtend(r_sample);
                w_next      = READ;
            end
            READ: begin
                o_hist_addr = r_wptr - r_cnt;
                o_coef_addr = r_cnt;
                if (r_cnt == LAST_TAP) w_next = DRAIN;
            end
            DRAIN: begin
                if (r_cnt == LAST_DRAIN) w_next = DONE;
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // r_cnt restarts at zero on every state change, so it is the tap index
    // in READ and the cycle index in DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Tap qualifier follows the RAM read and product register stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tapValid <= '0;
        end else begin
            r_tapValid <= {r_tapValid[0], r_state == READ};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample      <= '0;
            r_wptr        <= '0;
            r_result      <= '0;
            r_resultValid <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_resultValid <= 1'b0;
            if (w_accept) begin
                r_sample <= i_sample_in;
            end
            if (i_sample_valid && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
            if (r_state == DONE) begin
                r_result      <= fitResult(w_shifted);
                r_resultValid <= 1'b1;
                r_wptr        <= r_wptr + 1'b1;
            end
        end
    end

    fir_mac u_mac (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_accept),
        .i_acc_en (r_tapValid[1]),
        .i_a      (i_hist_dout[DATA_W-1:0]),
        .i_b      (i_coef_dout[COEF_W-1:0]),
        .o_acc    (w_acc)
    );

    assign o_result       = r_result;
    assign o_result_valid = r_resultValid;
    assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_fir_mac_engine.sv
// tb_fir_mac_engine
// Bench for fir_mac_engine with NTAPS=8, SHIFT=0. Models both RAMs and
// keeps an arithmetic reference of the history buffer and the FIR sum.
module tb_fir_mac_engine;

    localparam int TB_TAPS  = 8;
    localparam int TB_SHIFT = 0;
    localparam int LATENCY  = TB_TAPS + 5;

    logic        clk;
    logic        rst;
    logic [23:0] i_sample_in;
    logic        i_sample_valid;
    logic        o_sample_ready;
    logic        o_hist_we;
    logic [7:0]  o_hist_addr;
    logic [35:0] o_hist_din;
    logic [35:0] histDout;
    logic [7:0]  o_coef_addr;
    logic [35:0] coefDout;
    logic [23:0] o_result;
    logic        o_result_valid;
    logic        o_overrun;

    logic [35:0] histMem [256];
    logic [35:0] coefMem [256];

    longint      modelHist [256];
    int          modelWptr;

    int          testsRun;
    int          testsFailed;
    int          lastWriteAddr;
    logic [35:0] lastWriteDin;
    bit          sawWrap;

    typedef struct {
        logic [23:0] sample;
        logic [23:0] expResult;
    } vec_t;

    vec_t vecs [10];

    fir_mac_engine #(.NTAPS(TB_TAPS), .SHIFT(TB_SHIFT)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_sample_in    (i_sample_in),
        .i_sample_valid (i_sample_valid),
        .o_sample_ready (o_sample_ready),
        .o_hist_we      (o_hist_we),
        .o_hist_addr    (o_hist_addr),
        .o_hist_din     (o_hist_din),
        .i_hist_dout    (histDout),
        .o_coef_addr    (o_coef_addr),
        .i_coef_dout    (coefDout),
        .o_result       (o_result),
        .o_result_valid (o_result_valid),
        .o_overrun      (o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block RAM models: registered read, write on the same edge.
    always @(posedge clk) begin
        if (o_hist_we) histMem[o_hist_addr] <= o_hist_din;
        histDout <= histMem[o_hist_addr];
        coefDout <= coefMem[o_coef_addr];
    end

    // Records every history write to observe addresses and data.
    always @(negedge clk) begin
        if (o_hist_we) begin
            if (lastWriteAddr == 255 && o_hist_addr == 8'd0) sawWrap = 1'b1;
            lastWriteAddr = int'(o_hist_addr);
            lastWriteDin  = o_hist_din;
        end
    end

    task automatic checkOutput(input string name, input longint act, input longint exp);
        testsRun++;
        if (act != exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // FIR sum over the modelled history, newest sample at modelWptr.
    function automatic logic [23:0] modelExpected();
        longint acc;
        longint sh;
        acc = 0;
        for (int k = 0; k < TB_TAPS; k++) begin
            acc += modelHist[(modelWptr - k + 256) % 256] *
                   longint'($signed(coefMem[k][17:0]));
        end
        sh = acc >>> TB_SHIFT;
`ifdef FIR_SATURATE_EN
        if (sh > 64'sd8388607) return 24'h7FFFFF;
        if (sh < -64'sd8388608) return 24'h800000;
`endif
        return sh[23:0];
    endfunction

    // Presents one sample and follows it to its result. dropAt>0 raises
    // sample_valid once more so that the DUT sees it on that edge.
    task automatic applyStimulus(input logic [23:0] s, input int dropAt,
                                 output logic [23:0] res, output int validEdge,
                                 output bit readyOk);
        int waitCnt;
        waitCnt   = 0;
        validEdge = -1;
        readyOk   = 1'b1;
        res       = '0;
        while (!o_sample_ready && waitCnt < 100) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        i_sample_in    = s;
        i_sample_valid = 1'b1;
        @(posedge clk); #1;
        for (int e = 1; e <= 40; e++) begin
            i_sample_valid = (e == dropAt);
            @(posedge clk); #1;
            if (o_result_valid) begin
                validEdge = e;
                res       = o_result;
                if (!o_sample_ready) readyOk = 1'b0;
                break;
            end
            if (o_sample_ready) readyOk = 1'b0;
        end
        i_sample_valid = 1'b0;
    endtask

    task automatic doSample(input logic [23:0] s, input int dropAt, input string name,
                            input bit useTable, input logic [23:0] tableExp,
                            output logic [23:0] res);
        logic [23:0] exp;
        int          ve;
        bit          rok;
        modelHist[modelWptr] = longint'($signed(s));
        exp = useTable ? tableExp : modelExpected();
        applyStimulus(s, dropAt, res, ve, rok);
        modelWptr = (modelWptr + 1) % 256;
        checkOutput({name, " result"}, longint'(res), longint'(exp));
        checkOutput({name, " latency"}, longint'(ve), longint'(LATENCY));
        checkOutput({name, " ready"}, longint'(rok), 1);
        checkOutput({name, " din"}, longint'(lastWriteDin), longint'({{12{s[23]}}, s}));
    endtask

    initial begin
        logic [23:0] res;
        int          pulses;

        testsRun      = 0;
        testsFailed   = 0;
        modelWptr     = 0;
        lastWriteAddr = -1;
        lastWriteDin  = '0;
        sawWrap       = 1'b0;
        for (int i = 0; i < 256; i++) begin
            histMem[i]   = '0;
            coefMem[i]   = '0;
            modelHist[i] = 0;
        end
        for (int k = 0; k < TB_TAPS; k++) coefMem[k] = 36'(k + 1);

        vecs[0].sample    = 24'd1;
        vecs[0].expResult = 24'd1;
        for (int i = 1; i < 10; i++) begin
            vecs[i].sample    = 24'd0;
            vecs[i].expResult = (i < 8) ? 24'(i + 1) : 24'd0;
        end

        rst            = 1'b1;
        i_sample_in    = '0;
        i_sample_valid = 1'b0;
        #3;
        checkOutput("reset ready", longint'(o_sample_ready), 1);
        checkOutput("reset hist_we", longint'(o_hist_we), 0);
        checkOutput("reset hist_addr", longint'(o_hist_addr), 0);
        checkOutput("reset hist_din", longint'(o_hist_din), 0);
        checkOutput("reset coef_addr", longint'(o_coef_addr), 0);
        checkOutput("reset result", longint'(o_result), 0);
        checkOutput("reset result_valid", longint'(o_result_valid), 0);
        checkOutput("reset overrun", longint'(o_overrun), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Impulse response through coefficients 1..8.
        for (int i = 0; i < 10; i++) begin
            doSample(vecs[i].sample, 0, $sformatf("impulse%0d", i), 1'b1,
                     vecs[i].expResult, res);
        end
        checkOutput("overrun clear", longint'(o_overrun), 0);

        // Sample arriving during DONE, then one arriving during READ.
        doSample(24'd500, LATENCY, "drop in DONE", 1'b0, '0, res);
        checkOutput("overrun after DONE drop", longint'(o_overrun), 1);
        doSample(24'hFFFF38, 3, "drop in READ", 1'b0, '0, res);
        checkOutput("overrun sticky", longint'(o_overrun), 1);

        // Constant input across a write pointer wrap.
        for (int k = 0; k < TB_TAPS; k++) coefMem[k] = 36'd1;
        for (int i = 0; i < 300; i++) begin
            doSample(24'd1000, 0, $sformatf("const%0d", i), 1'b0, '0, res);
        end
        checkOutput("steady state", longint'(res), 8000);
        checkOutput("hist_addr wrap", longint'(sawWrap), 1);

        // Full-scale input times full-scale coefficients.
        for (int k = 0; k < TB_TAPS; k++) coefMem[k] = 36'h1FFFF;
        for (int i = 0; i < TB_TAPS; i++) begin
            doSample(24'h7FFFFF, 0, $sformatf("full%0d", i), 1'b0, '0, res);
        end
`ifdef FIR_SATURATE_EN
        checkOutput("full scale", longint'(res), longint'(24'h7FFFFF));
`else
        checkOutput("full scale", longint'(res), longint'(24'hF00008));
`endif

        // Random samples and coefficients against the reference model.
        for (int i = 0; i < 40; i++) begin
            if (i % 10 == 0) begin
                for (int k = 0; k < TB_TAPS; k++) begin
                    coefMem[k] = {18'($urandom), 18'($urandom)};
                end
            end
            doSample(24'($urandom), 0, $sformatf("rand%0d", i), 1'b0, '0, res);
        end

        // Reset in the middle of READ.
        i_sample_in    = 24'd77;
        i_sample_valid = 1'b1;
        modelHist[modelWptr] = 77;
        @(posedge clk); #1;
        i_sample_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort ready", longint'(o_sample_ready), 1);
        checkOutput("abort hist_we", longint'(o_hist_we), 0);
        checkOutput("abort hist_addr", longint'(o_hist_addr), 0);
        checkOutput("abort coef_addr", longint'(o_coef_addr), 0);
        checkOutput("abort result", longint'(o_result), 0);
        checkOutput("abort result_valid", longint'(o_result_valid), 0);
        checkOutput("abort overrun", longint'(o_overrun), 0);
        modelWptr = 0;
        pulses    = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (c == 1) rst = 1'b0;
            if (o_result_valid) pulses++;
        end
        checkOutput("abort no result", longint'(pulses), 0);
        for (int k = 0; k < TB_TAPS; k++) coefMem[k] = 36'(k + 3);
        doSample(24'd12345, 0, "after abort", 1'b0, '0, res);
        checkOutput("after abort addr", longint'(lastWriteAddr), 0);
        doSample(24'hABCDEF, 0, "after abort 2", 1'b0, '0, res);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
